exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 29 ++
 rtl/exc_prio.sv | 22 ++
 rtl/exc_ctrl.sv | 107 ++++++++++
 tb/tb_exc_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, masks, exception codes.
// Also carries the data-memory access size codes used by the LSU.
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [31:0] SR_WMASK   = 32'h0000_FC03;
  localparam logic [31:0] PRID_VAL   = 32'h0000_4D50;
  localparam logic [31:0] VECTOR_DEF = 32'h0000_4180;

  localparam logic [1:0] DM_WORD = 2'd0;
  localparam logic [1:0] DM_HALF = 2'd1;
  localparam logic [1:0] DM_BYTE = 2'd2;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_prio.sv
// Combinational arbitration: interrupt over exception, EPC select.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic        valid,
  input  logic        exl,
  input  logic        int_pend,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc,
  input  logic        bd,
  output logic        req,
  output logic [4:0]  code,
  output logic [31:0] epc
);

  always_comb begin
    req  = valid & ~exl & (int_pend | (exc_code != EXC_INT));
    code = int_pend ? EXC_INT : exc_code;
    epc  = bd ? (pc - 32'd4) : pc;
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, trap entry and eret.
// EXL is the RUN/HANDLER state; Cause.IP samples the lines every cycle.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR = VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  XC_i_ExcCode,
  input  logic [31:0] XC_i_PC,
  input  logic        XC_i_BD,
  input  logic        XC_i_Valid,
  input  logic [5:0]  XC_i_HWInt,
  input  logic        XC_i_Eret,
  input  logic        XC_i_WEnable,
  input  logic [4:0]  XC_i_WAddr,
  input  logic [31:0] XC_i_WData,
  input  logic [4:0]  XC_i_RAddr,
  output logic [31:0] XC_o_RData,
  output logic        XC_o_Req,
  output logic [31:0] XC_o_EPC,
  output logic [31:0] XC_o_Vector
);

  exc_state_e  state;
  logic [5:0]  im;
  logic        ie;
  logic        cause_bd;
  logic [5:0]  ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        exl;
  logic        int_pend;
  logic        req;
  logic [4:0]  code;
  logic [31:0] epc_next;
  logic [31:0] sr;
  logic [31:0] cause;
  logic [31:0] sr_w;

  assign exl      = (state == ST_HANDLER);
  assign int_pend = ie & (|(XC_i_HWInt & im));
  assign sr       = {16'b0, im, 8'b0, exl, ie};
  assign cause    = {cause_bd, 15'b0, ip, 3'b0, cause_exc, 2'b0};
  assign sr_w     = XC_i_WData & SR_WMASK;

  exc_prio u_prio (
    .valid    (XC_i_Valid),
    .exl      (exl),
    .int_pend (int_pend),
    .exc_code (XC_i_ExcCode),
    .pc       (XC_i_PC),
    .bd       (XC_i_BD),
    .req      (req),
    .code     (code),
    .epc      (epc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      im        <= '0;
      ie        <= 1'b0;
      cause_bd  <= 1'b0;
      ip        <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      ip <= XC_i_HWInt;
      if (req) begin
        state     <= ST_HANDLER;
        cause_bd  <= XC_i_BD;
        cause_exc <= code;
        epc       <= epc_next;
      end else begin
        if (XC_i_Eret && exl)
          state <= ST_RUN;
        // an mtc0 to SR in the same cycle overrides the eret
        if (XC_i_WEnable && XC_i_WAddr == CP0_SR) begin
          im    <= sr_w[15:10];
          ie    <= sr_w[0];
          state <= exc_state_e'(sr_w[1]);
        end
        if (XC_i_WEnable && XC_i_WAddr == CP0_EPC)
          epc <= XC_i_WData;
      end
    end
  end

  always_comb begin
    XC_o_RData = '0;
    case (XC_i_RAddr)
      CP0_SR:    XC_o_RData = sr;
      CP0_CAUSE: XC_o_RData = cause;
      CP0_EPC:   XC_o_RData = epc;
      CP0_PRID:  XC_o_RData = PRID_VAL;
      default:   XC_o_RData = '0;
    endcase
  end

  assign XC_o_Req    = req;
  assign XC_o_EPC    = epc;
  assign XC_o_Vector = VECTOR;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: trap entry, priority, eret, mtc0/mfc0, reset.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  exc_code;
  logic [31:0] pc;
  logic        bd;
  logic        valid;
  logic [5:0]  hw_int;
  logic        eret;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] epc_o;
  logic [31:0] vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .XC_i_ExcCode (exc_code),
    .XC_i_PC      (pc),
    .XC_i_BD      (bd),
    .XC_i_Valid   (valid),
    .XC_i_HWInt   (hw_int),
    .XC_i_Eret    (eret),
    .XC_i_WEnable (wen),
    .XC_i_WAddr   (waddr),
    .XC_i_WData   (wdata),
    .XC_i_RAddr   (raddr),
    .XC_o_RData   (rdata),
    .XC_o_Req     (req),
    .XC_o_EPC     (epc_o),
    .XC_o_Vector  (vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a,
                         input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, req}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; exc_code = '0; pc = 32'h1000; bd = 1'b0;
    valid = 1'b0; hw_int = '0; eret = 1'b0; wen = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    #2;
    chk_reg("rst_sr", CP0_SR, 32'h0);
    chk_reg("rst_cause", CP0_CAUSE, 32'h0);
    chk_reg("rst_epc", CP0_EPC, 32'h0);
    chk_reg("prid", CP0_PRID, 32'h0000_4D50);
    chk("vector", vec, 32'h0000_4180);
    chk_req("rst_req", 1'b0);
    #5 reset = 1'b0;
    tick();

    // enable IE and IM[0] with line 0 already high
    wen = 1'b1; waddr = CP0_SR; wdata = 32'h0000_0401;
    hw_int = 6'b000001; valid = 1'b1;
    chk_req("a_no_req_yet", 1'b0);
    tick();
    wen = 1'b0;
    chk_req("a_int_req", 1'b1);
    tick();
    chk_reg("a_sr", CP0_SR, 32'h0000_0403);
    chk_reg("a_cause", CP0_CAUSE, 32'h0000_0400);
    chk_reg("a_epc", CP0_EPC, 32'h0000_1000);
    chk_req("a_handler_req", 1'b0);

    // eret, then overflow in a delay slot
    eret = 1'b1; hw_int = '0;
    tick();
    eret = 1'b0;
    chk_reg("b_sr_eret", CP0_SR, 32'h0000_0401);
    exc_code = EXC_OV; pc = 32'h3008; bd = 1'b1;
    chk_req("b_ov_req", 1'b1);
    tick();
    exc_code = '0; bd = 1'b0;
    chk_reg("b_epc", CP0_EPC, 32'h0000_3004);
    chk("b_epc_port", epc_o, 32'h0000_3004);
    chk_reg("b_cause", CP0_CAUSE, 32'h8000_0030);

    // everything masked while in the handler
    exc_code = 5'd4; hw_int = 6'h3F;
    chk_req("c_masked", 1'b0);
    tick();
    chk_reg("c_epc_kept", CP0_EPC, 32'h0000_3004);
    chk_reg("c_cause_ip", CP0_CAUSE, 32'h8000_FC30);
    exc_code = '0; hw_int = '0; eret = 1'b1;
    tick();
    eret = 1'b0;
    chk_reg("c_exl_clr", CP0_SR, 32'h0000_0401);

    // interrupt and exception together: interrupt wins
    hw_int = 6'b000001; exc_code = 5'd5; pc = 32'h4000;
    chk_req("d_req", 1'b1);
    tick();
    hw_int = '0; exc_code = '0;
    chk_reg("d_cause", CP0_CAUSE, 32'h0000_0400);
    chk_reg("d_epc", CP0_EPC, 32'h0000_4000);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // plain mtc0 EPC: old value visible until the edge
    wen = 1'b1; waddr = CP0_EPC; wdata = 32'h0000_1234;
    chk_reg("e_epc_pre", CP0_EPC, 32'h0000_4000);
    tick();
    waddr = CP0_CAUSE; wdata = 32'hFFFF_FFFF;
    chk_reg("e_epc_post", CP0_EPC, 32'h0000_1234);
    tick();
    waddr = 5'd20;
    chk_reg("e_cause_ro", CP0_CAUSE, 32'h0);
    tick();
    wen = 1'b0;
    chk_reg("e_reg20", 5'd20, 32'h0);

    // trap wins over same-cycle mtc0 EPC
    wen = 1'b1; waddr = CP0_EPC; wdata = 32'hDEAD_BEEF;
    exc_code = EXC_OV; pc = 32'h5000;
    chk_req("f_req", 1'b1);
    tick();
    wen = 1'b0; exc_code = '0;
    chk_reg("f_epc", CP0_EPC, 32'h0000_5000);
    chk_reg("f_cause", CP0_CAUSE, 32'h0000_0030);
    chk_reg("f_reg20", 5'd20, 32'h0);

    // asynchronous reset pulse in the middle of the handler
    @(posedge clk);
    #3 reset = 1'b1;
    chk_reg("g_sr", CP0_SR, 32'h0);
    chk_reg("g_cause", CP0_CAUSE, 32'h0);
    chk_reg("g_epc", CP0_EPC, 32'h0);
    chk_req("g_req", 1'b0);
    reset = 1'b0;
    tick();
    exc_code = EXC_OV; pc = 32'h6000;
    chk_req("g_run_req", 1'b1);
    tick();
    exc_code = '0;
    chk_reg("g_epc2", CP0_EPC, 32'h0000_6000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
